// File: rtl/sram_req_arbiter.sv
// Two-to-one sram-like request arbiter: data-priority grant held until accept,
// with an in-order owner FIFO that steers each response back to its issuer.
module sram_req_arbiter #(
  parameter int OT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        out_req,
  output logic        out_wr,
  output logic [1:0]  out_size,
  output logic [3:0]  out_wstrb,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata,
  input  logic        out_addr_ok,
  input  logic        out_data_ok,
  input  logic [31:0] out_rdata,

  output logic        arb_err
);
  localparam int PW = $clog2(OT_DEPTH);
  localparam logic [PW:0]   FULL  = (PW+1)'(OT_DEPTH);
  localparam logic [PW:0]   C_ONE = 1;
  localparam logic [PW-1:0] P_ONE = 1;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  sram_req_t inst_r, data_r, gnt_r;
  logic               lock, lock_owner, grant, gnt_req, hs, pop, owner_head;
  logic [OT_DEPTH-1:0] owner_q;
  logic [PW-1:0]      wptr, rptr;
  logic [PW:0]        cnt;

  assign inst_r = {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata};
  assign data_r = {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata};

  // grant: 0 = inst, 1 = data; an idle unlocked cycle defaults to inst
  assign grant   = lock ? lock_owner : data_sram_req;
  assign gnt_req = grant ? data_sram_req : inst_sram_req;
  assign gnt_r   = grant ? data_r : inst_r;

  assign out_req   = resetn & gnt_req & (cnt != FULL);
  assign out_wr    = gnt_r.wr;
  assign out_size  = gnt_r.size;
  assign out_wstrb = gnt_r.wstrb;
  assign out_addr  = gnt_r.addr;
  assign out_wdata = gnt_r.wdata;

  assign hs                = out_req & out_addr_ok;
  assign inst_sram_addr_ok = hs & ~grant;
  assign data_sram_addr_ok = hs & grant;

  // a response with nothing outstanding is dropped and only flags arb_err
  assign pop               = resetn & out_data_ok & (cnt != '0);
  assign owner_head        = owner_q[rptr];
  assign inst_sram_data_ok = pop & ~owner_head;
  assign data_sram_data_ok = pop & owner_head;
  assign inst_sram_rdata   = out_rdata;
  assign data_sram_rdata   = out_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock       <= 1'b0;
      lock_owner <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      arb_err    <= 1'b0;
    end else begin
      if (hs) begin
        lock <= 1'b0;
        wptr <= wptr + P_ONE;
      end else if (out_req) begin
        lock       <= 1'b1;
        lock_owner <= grant;
      end
      if (pop) rptr <= rptr + P_ONE;
      case ({hs, pop})
        2'b10:   cnt <= cnt + C_ONE;
        2'b01:   cnt <= cnt - C_ONE;
        default: cnt <= cnt;
      endcase
      if (out_data_ok && cnt == '0) arb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && hs) owner_q[wptr] <= grant;
  end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: a vector table for the basic flows plus
// hand sequences for FIFO full/wrap and reset with requests outstanding.
module tb_sram_req_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        out_req, out_wr;
  logic [1:0]  out_size;
  logic [3:0]  out_wstrb;
  logic [31:0] out_addr, out_wdata;
  logic        out_addr_ok, out_data_ok;
  logic [31:0] out_rdata;
  logic        arb_err;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OT_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .out_req(out_req), .out_wr(out_wr), .out_size(out_size), .out_wstrb(out_wstrb),
    .out_addr(out_addr), .out_wdata(out_wdata), .out_addr_ok(out_addr_ok),
    .out_data_ok(out_data_ok), .out_rdata(out_rdata), .arb_err(arb_err)
  );

  // fixed per-master attributes so the mux source is visible on every out_* field
  localparam logic [31:0] I_WDATA = 32'h1111_0000, D_WDATA = 32'hDDDD_0000;
  localparam logic [3:0]  I_WSTRB = 4'h3,          D_WSTRB = 4'hC;
  localparam logic [1:0]  I_SIZE  = 2'd2,          D_SIZE  = 2'd1;
  localparam logic [31:0] IA0 = 32'h1C00_0000, IA1 = 32'h1C00_0010, IA2 = 32'h1C00_0020;
  localparam logic [31:0] DA1 = 32'h8000_1000, DA2 = 32'h8000_2000;

  typedef struct {
    logic        rst_n, ireq, dreq, aok, dok;
    logic [31:0] iaddr, daddr, rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_wr, e_iaok, e_daok, e_idok, e_ddok, e_err;
  } vec_t;

  int    n_chk = 0;
  int    n_fail = 0;
  string tag;

  function automatic vec_t mk(logic r, logic ireq, logic [31:0] ia, logic dreq, logic [31:0] da,
                              logic aok, logic dok, logic [31:0] rd,
                              logic ereq, logic [31:0] eaddr, logic ewr,
                              logic eia, logic eda, logic eid, logic edd, logic eerr);
    vec_t v;
    v.rst_n = r; v.ireq = ireq; v.iaddr = ia; v.dreq = dreq; v.daddr = da;
    v.aok = aok; v.dok = dok; v.rdata = rd;
    v.e_req = ereq; v.e_addr = eaddr; v.e_wr = ewr;
    v.e_iaok = eia; v.e_daok = eda; v.e_idok = eid; v.e_ddok = edd; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  // drive one cycle (inputs set just after the rising edge), check mid-cycle, advance
  task automatic apply(input vec_t v);
    resetn = v.rst_n;
    inst_sram_req = v.ireq; inst_sram_addr = v.iaddr;
    data_sram_req = v.dreq; data_sram_addr = v.daddr;
    out_addr_ok = v.aok; out_data_ok = v.dok; out_rdata = v.rdata;
    #4;
    chk("out_req", 32'(out_req), 32'(v.e_req));
    chk("out_addr", out_addr, v.e_addr);
    chk("out_wr", 32'(out_wr), 32'(v.e_wr));
    chk("out_wdata", out_wdata, v.e_wr ? D_WDATA : I_WDATA);
    chk("out_wstrb", 32'(out_wstrb), 32'(v.e_wr ? D_WSTRB : I_WSTRB));
    chk("out_size", 32'(out_size), 32'(v.e_wr ? D_SIZE : I_SIZE));
    chk("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(v.e_iaok));
    chk("data_addr_ok", 32'(data_sram_addr_ok), 32'(v.e_daok));
    chk("inst_data_ok", 32'(inst_sram_data_ok), 32'(v.e_idok));
    chk("data_data_ok", 32'(data_sram_data_ok), 32'(v.e_ddok));
    chk("arb_err", 32'(arb_err), 32'(v.e_err));
    if (v.dok) begin
      chk("inst_rdata", inst_sram_rdata, v.rdata);
      chk("data_rdata", data_sram_rdata, v.rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input int exp);
    chk("cnt", 32'(dut.cnt), 32'(exp));
  endtask

  vec_t tbl[18];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //             r ireq ia  dreq da  aok dok rdata          req addr wr ia da id dd err
    tbl[0]  = mk(0, 1, IA0, 0, DA1, 1, 0, 32'h0,          0, IA0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, IA0, 0, DA1, 1, 0, 32'h0,          1, IA0, 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, IA0, 0, DA1, 0, 0, 32'h0,          0, IA0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, IA0, 0, DA1, 0, 1, 32'h0280_0C04,  0, IA0, 0, 0, 0, 1, 0, 0);
    tbl[4]  = mk(1, 1, IA1, 1, DA1, 1, 0, 32'h0,          1, DA1, 1, 0, 1, 0, 0, 0);
    tbl[5]  = mk(1, 1, IA1, 0, DA1, 1, 0, 32'h0,          1, IA1, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, IA1, 0, DA1, 0, 1, 32'h1111_1111,  0, IA1, 0, 0, 0, 0, 1, 0);
    tbl[7]  = mk(1, 0, IA1, 0, DA1, 0, 1, 32'h2222_2222,  0, IA1, 0, 0, 0, 1, 0, 0);
    tbl[8]  = mk(1, 1, IA2, 0, DA2, 0, 0, 32'h0,          1, IA2, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 1, IA2, 1, DA2, 0, 0, 32'h0,          1, IA2, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 1, IA2, 1, DA2, 0, 0, 32'h0,          1, IA2, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, IA2, 1, DA2, 1, 0, 32'h0,          1, IA2, 0, 1, 0, 0, 0, 0);
    tbl[12] = mk(1, 0, IA2, 1, DA2, 1, 0, 32'h0,          1, DA2, 1, 0, 1, 0, 0, 0);
    tbl[13] = mk(1, 0, IA2, 0, DA2, 0, 1, 32'h3333_3333,  0, IA2, 0, 0, 0, 1, 0, 0);
    tbl[14] = mk(1, 0, IA2, 0, DA2, 0, 1, 32'h4444_4444,  0, IA2, 0, 0, 0, 0, 1, 0);
    tbl[15] = mk(1, 0, IA2, 0, DA2, 0, 1, 32'h5555_5555,  0, IA2, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(1, 0, IA2, 0, DA2, 0, 0, 32'h0,          0, IA2, 0, 0, 0, 0, 0, 1);
    tbl[17] = mk(1, 0, IA2, 0, DA2, 0, 0, 32'h0,          0, IA2, 0, 0, 0, 0, 0, 1);

    inst_sram_wr = 1'b0; inst_sram_size = I_SIZE; inst_sram_wstrb = I_WSTRB; inst_sram_wdata = I_WDATA;
    data_sram_wr = 1'b1; data_sram_size = D_SIZE; data_sram_wstrb = D_WSTRB; data_sram_wdata = D_WDATA;
    resetn = 1'b0; inst_sram_req = 1'b0; data_sram_req = 1'b0;
    inst_sram_addr = IA0; data_sram_addr = DA1;
    out_addr_ok = 1'b0; out_data_ok = 1'b0; out_rdata = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      tag = $sformatf("vec%0d", i);
      apply(tbl[i]);
    end

    // fill to OT_DEPTH, stall, pop+blocked push, wrap wptr, drain in order
    tag = "full";
    apply(mk(0, 0, IA0, 0, DA1, 0, 0, 32'h0,         0, IA0, 0, 0, 0, 0, 0, 1));
    apply(mk(1, 1, IA0, 0, DA1, 1, 0, 32'h0,         1, IA0, 0, 1, 0, 0, 0, 0));
    apply(mk(1, 0, IA0, 1, DA1, 1, 0, 32'h0,         1, DA1, 1, 0, 1, 0, 0, 0));
    apply(mk(1, 1, IA1, 0, DA1, 1, 0, 32'h0,         1, IA1, 0, 1, 0, 0, 0, 0));
    apply(mk(1, 0, IA1, 1, DA2, 1, 0, 32'h0,         1, DA2, 1, 0, 1, 0, 0, 0));
    chk_cnt(4);
    apply(mk(1, 1, IA2, 0, DA2, 1, 0, 32'h0,         0, IA2, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 1, IA2, 0, DA2, 1, 1, 32'hA000_0000, 0, IA2, 0, 0, 0, 1, 0, 0));
    chk_cnt(3);
    apply(mk(1, 1, IA2, 0, DA2, 1, 0, 32'h0,         1, IA2, 0, 1, 0, 0, 0, 0));
    chk_cnt(4);
    chk("wptr_wrap", 32'(dut.wptr), 32'd1);
    apply(mk(1, 0, IA2, 0, DA2, 0, 1, 32'hA000_0001, 0, IA2, 0, 0, 0, 0, 1, 0));
    apply(mk(1, 0, IA2, 1, DA2, 1, 1, 32'hA000_0002, 1, DA2, 1, 0, 1, 1, 0, 0));
    chk_cnt(3);
    apply(mk(1, 0, IA2, 0, DA2, 0, 1, 32'hA000_0003, 0, IA2, 0, 0, 0, 0, 1, 0));
    apply(mk(1, 0, IA2, 0, DA2, 0, 1, 32'hA000_0004, 0, IA2, 0, 0, 0, 1, 0, 0));
    apply(mk(1, 0, IA2, 0, DA2, 0, 1, 32'hA000_0005, 0, IA2, 0, 0, 0, 0, 1, 0));
    chk_cnt(0);
    apply(mk(1, 0, IA2, 0, DA2, 0, 1, 32'hA000_0006, 0, IA2, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 0, IA2, 0, DA2, 0, 0, 32'h0,         0, IA2, 0, 0, 0, 0, 0, 1));

    // reset with two outstanding and a held grant; a late response is spurious
    tag = "rst";
    apply(mk(0, 0, IA0, 0, DA1, 0, 0, 32'h0,         0, IA0, 0, 0, 0, 0, 0, 1));
    apply(mk(1, 1, IA0, 0, DA1, 1, 0, 32'h0,         1, IA0, 0, 1, 0, 0, 0, 0));
    apply(mk(1, 0, IA0, 1, DA1, 1, 0, 32'h0,         1, DA1, 1, 0, 1, 0, 0, 0));
    chk_cnt(2);
    apply(mk(1, 1, IA1, 0, DA1, 0, 0, 32'h0,         1, IA1, 0, 0, 0, 0, 0, 0));
    chk("lock_set", 32'(dut.lock), 32'd1);
    apply(mk(0, 1, IA1, 1, DA1, 1, 1, 32'hB000_0000, 0, IA1, 0, 0, 0, 0, 0, 0));
    chk_cnt(0);
    chk("lock_clr", 32'(dut.lock), 32'd0);
    apply(mk(1, 1, IA1, 1, DA2, 0, 0, 32'h0,         1, DA2, 1, 0, 0, 0, 0, 0));
    apply(mk(1, 0, IA1, 0, DA2, 0, 1, 32'hB000_0001, 0, DA2, 1, 0, 0, 0, 0, 0));
    apply(mk(1, 0, IA1, 0, DA2, 0, 0, 32'h0,         0, DA2, 1, 0, 0, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
